// File: rtl/cmd_cfg_pkg.sv
// Shared types and constants for the host command/configuration unit.
package cmd_cfg_pkg;

  typedef enum logic [1:0] {
    OpRead    = 2'b00,
    OpWrite   = 2'b01,
    OpDump    = 2'b10,
    OpInvalid = 2'b11
  } opcode_e;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StResp     = 3'd1;
  localparam state_t StWaitSent = 3'd2;
  localparam state_t StDumpAddr = 3'd3;
  localparam state_t StDumpLat  = 3'd4;
  localparam state_t StDumpSend = 3'd5;
  localparam state_t StDumpWait = 3'd6;

  localparam logic [4:0] REG_TRIGCFG    = 5'h00;
  localparam logic [4:0] REG_DECIM      = 5'h01;
  localparam logic [4:0] REG_VIH        = 5'h02;
  localparam logic [4:0] REG_VIL        = 5'h03;
  localparam logic [4:0] REG_MATCHH     = 5'h04;
  localparam logic [4:0] REG_MATCHL     = 5'h05;
  localparam logic [4:0] REG_MASKH      = 5'h06;
  localparam logic [4:0] REG_MASKL      = 5'h07;
  localparam logic [4:0] REG_BAUDH      = 5'h08;
  localparam logic [4:0] REG_BAUDL      = 5'h09;
  localparam logic [4:0] REG_TRIGPOSH   = 5'h0A;
  localparam logic [4:0] REG_TRIGPOSL   = 5'h0B;
  localparam logic [4:0] REG_CHCFG_BASE = 5'h10;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  localparam logic [5:0]  RST_TRIGCFG   = 6'h03;
  localparam logic [4:0]  RST_CHCFG     = 5'h01;
  localparam logic [7:0]  RST_VIH       = 8'hAA;
  localparam logic [7:0]  RST_VIL       = 8'h55;
  localparam logic [15:0] RST_BAUD      = 16'h06C8;
  localparam logic [7:0]  RST_TRIGPOS_L = 8'h01;

  function automatic logic is_mapped(input logic [4:0] addr, input int unsigned num_ch);
    return (addr <= REG_TRIGPOSL) ||
           ((addr >= REG_CHCFG_BASE) && ((32'(addr) - 32'(REG_CHCFG_BASE)) < num_ch));
  endfunction

endpackage

// File: rtl/cmd_cfg_gen_if.sv
// Host-side command/response handshake between the UART blocks and the command unit.
interface cmd_cfg_gen_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (output cmd, output cmd_rdy, output resp_sent,
                  input clr_cmd_rdy, input resp, input send_resp);
  modport slave  (input cmd, input cmd_rdy, input resp_sent,
                  output clr_cmd_rdy, output resp, output send_resp);
endinterface

// File: rtl/cfg_regfile.sv
// Configuration registers: write decode, read mux and capture_done set/clear priority.
module cfg_regfile
  import cmd_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned LOG2   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            addr,
  input  logic [7:0]            wdata,
  input  logic                  set_capture_done,
  input  logic                  clr_capture_done,
  output logic [7:0]            rd_data,
  output logic                  mapped,
  output logic [LOG2-1:0]       trig_pos,
  output logic [3:0]            decimator,
  output logic [7:0]            maskL,
  output logic [7:0]            maskH,
  output logic [7:0]            matchL,
  output logic [7:0]            matchH,
  output logic [7:0]            baud_cntL,
  output logic [7:0]            baud_cntH,
  output logic [5:0]            TrigCfg,
  output logic [NUM_CH*5-1:0]   ChTrigCfg
);

  logic [5:0]      trig_cfg_q;
  logic            done_d;
  logic [3:0]      decim_q;
  logic [7:0]      vih_q, vil_q, match_h_q, match_l_q, mask_h_q, mask_l_q;
  logic [7:0]      baud_h_q, baud_l_q, tpos_l_q;
  logic [LOG2-9:0] tpos_h_q;
  logic [4:0]      ch_cfg_q [NUM_CH];

  assign mapped = is_mapped(addr, NUM_CH);

  // set_capture_done beats both a register write and the dump-completion clear
  always_comb begin
    done_d = trig_cfg_q[4];
    if (clr_capture_done) done_d = 1'b0;
    if (we && (addr == REG_TRIGCFG)) done_d = wdata[4];
    if (set_capture_done) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_cfg_q <= RST_TRIGCFG;
      decim_q    <= '0;
      vih_q      <= RST_VIH;
      vil_q      <= RST_VIL;
      match_h_q  <= '0;
      match_l_q  <= '0;
      mask_h_q   <= '0;
      mask_l_q   <= '0;
      baud_h_q   <= RST_BAUD[15:8];
      baud_l_q   <= RST_BAUD[7:0];
      tpos_h_q   <= '0;
      tpos_l_q   <= RST_TRIGPOS_L;
      for (int i = 0; i < NUM_CH; i++) ch_cfg_q[i] <= RST_CHCFG;
    end else begin
      trig_cfg_q[4] <= done_d;
      if (we) begin
        case (addr)
          REG_TRIGCFG:  {trig_cfg_q[5], trig_cfg_q[3:0]} <= {wdata[5], wdata[3:0]};
          REG_DECIM:    decim_q   <= wdata[3:0];
          REG_VIH:      vih_q     <= wdata;
          REG_VIL:      vil_q     <= wdata;
          REG_MATCHH:   match_h_q <= wdata;
          REG_MATCHL:   match_l_q <= wdata;
          REG_MASKH:    mask_h_q  <= wdata;
          REG_MASKL:    mask_l_q  <= wdata;
          REG_BAUDH:    baud_h_q  <= wdata;
          REG_BAUDL:    baud_l_q  <= wdata;
          REG_TRIGPOSH: tpos_h_q  <= wdata[LOG2-9:0];
          REG_TRIGPOSL: tpos_l_q  <= wdata;
          default: begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (addr == REG_CHCFG_BASE + 5'(i)) ch_cfg_q[i] <= wdata[4:0];
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_TRIGCFG:  rd_data = {2'b00, trig_cfg_q};
      REG_DECIM:    rd_data = {4'h0, decim_q};
      REG_VIH:      rd_data = vih_q;
      REG_VIL:      rd_data = vil_q;
      REG_MATCHH:   rd_data = match_h_q;
      REG_MATCHL:   rd_data = match_l_q;
      REG_MASKH:    rd_data = mask_h_q;
      REG_MASKL:    rd_data = mask_l_q;
      REG_BAUDH:    rd_data = baud_h_q;
      REG_BAUDL:    rd_data = baud_l_q;
      REG_TRIGPOSH: rd_data = 8'(tpos_h_q);
      REG_TRIGPOSL: rd_data = tpos_l_q;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (addr == REG_CHCFG_BASE + 5'(i)) rd_data = {3'b000, ch_cfg_q[i]};
        end
      end
    endcase
  end

  assign trig_pos  = {tpos_h_q, tpos_l_q};
  assign decimator = decim_q;
  assign maskL     = mask_l_q;
  assign maskH     = mask_h_q;
  assign matchL    = match_l_q;
  assign matchH    = match_h_q;
  assign baud_cntL = baud_l_q;
  assign baud_cntH = baud_h_q;
  assign TrigCfg   = trig_cfg_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch_out
    assign ChTrigCfg[g*5 +: 5] = ch_cfg_q[g];
  end

endmodule

// File: rtl/cmd_cfg_gen.sv
// Host command decoder: register read/write responses and channel-RAM dump sequencing.
module cmd_cfg_gen
  import cmd_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH  = 5,
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic                clk,
  input  logic                rst,
  cmd_cfg_gen_if.slave        host,
  input  logic                set_capture_done,
  input  logic [LOG2-1:0]     start_addr,
  input  logic [NUM_CH*8-1:0] rdata,
  output logic [LOG2-1:0]     raddr,
  output logic [LOG2-1:0]     trig_pos,
  output logic [3:0]          decimator,
  output logic [7:0]          maskL,
  output logic [7:0]          maskH,
  output logic [7:0]          matchL,
  output logic [7:0]          matchH,
  output logic [7:0]          baud_cntL,
  output logic [7:0]          baud_cntH,
  output logic [5:0]          TrigCfg,
  output logic [NUM_CH*5-1:0] ChTrigCfg
);

  localparam logic [LOG2-1:0] LastIdx = LOG2'(ENTRIES - 1);

  state_t          state_q, state_d;
  logic [7:0]      resp_q, resp_d;
  logic            send_q, send_d, clr_q, clr_d;
  logic [LOG2-1:0] raddr_q, raddr_d, cnt_q, cnt_d;
  logic [3:0]      ch_q, ch_d;
  logic            reg_we, clr_done, mapped;
  logic [7:0]      reg_rdata;
  opcode_e         op;
  logic [4:0]      cmd_ch;
  logic            dump_ok;
  logic            unused_cmd;

  assign op         = opcode_e'(host.cmd[15:14]);
  assign cmd_ch     = host.cmd[12:8];
  assign dump_ok    = (cmd_ch != 5'd0) && (32'(cmd_ch) <= NUM_CH);
  assign unused_cmd = host.cmd[13];

  cfg_regfile #(
    .NUM_CH (NUM_CH),
    .LOG2   (LOG2)
  ) u_regfile (
    .clk              (clk),
    .rst              (rst),
    .we               (reg_we),
    .addr             (host.cmd[12:8]),
    .wdata            (host.cmd[7:0]),
    .set_capture_done (set_capture_done),
    .clr_capture_done (clr_done),
    .rd_data          (reg_rdata),
    .mapped           (mapped),
    .trig_pos         (trig_pos),
    .decimator        (decimator),
    .maskL            (maskL),
    .maskH            (maskH),
    .matchL           (matchL),
    .matchH           (matchH),
    .baud_cntL        (baud_cntL),
    .baud_cntH        (baud_cntH),
    .TrigCfg          (TrigCfg),
    .ChTrigCfg        (ChTrigCfg)
  );

  always_comb begin
    state_d  = state_q;
    resp_d   = resp_q;
    send_d   = 1'b0;
    clr_d    = 1'b0;
    raddr_d  = raddr_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    reg_we   = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      StIdle: begin
        // cmd_rdy is still high in the cycle our registered clr_cmd_rdy is visible
        if (host.cmd_rdy && !clr_q) begin
          state_d = StResp;
          send_d  = 1'b1;
          clr_d   = 1'b1;
          resp_d  = RESP_NAK;
          unique case (op)
            OpRead:  if (mapped) resp_d = reg_rdata;
            OpWrite: begin
              if (mapped) begin
                reg_we = 1'b1;
                resp_d = RESP_ACK;
              end
            end
            OpDump: begin
              if (dump_ok) begin
                state_d = StDumpAddr;
                send_d  = 1'b0;
                clr_d   = 1'b0;
                resp_d  = resp_q;
                raddr_d = start_addr;
                cnt_d   = '0;
                ch_d    = 4'(cmd_ch - 5'd1);
              end
            end
            default: ;
          endcase
        end
      end
      StResp:     state_d = StWaitSent;
      StWaitSent: if (host.resp_sent) state_d = StIdle;
      StDumpAddr: state_d = StDumpLat;
      StDumpLat:  state_d = StDumpSend;
      StDumpSend: begin
        resp_d  = rdata[{ch_q, 3'b000} +: 8];
        send_d  = 1'b1;
        state_d = StDumpWait;
      end
      StDumpWait: begin
        if (host.resp_sent) begin
          if (cnt_q == LastIdx) begin
            clr_d    = 1'b1;
            clr_done = 1'b1;
            state_d  = StIdle;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            raddr_d = (raddr_q == LastIdx) ? '0 : raddr_q + 1'b1;
            state_d = StDumpAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      resp_q  <= '0;
      send_q  <= 1'b0;
      clr_q   <= 1'b0;
      raddr_q <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      send_q  <= send_d;
      clr_q   <= clr_d;
      raddr_q <= raddr_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
    end
  end

  assign host.resp        = resp_q;
  assign host.send_resp   = send_q;
  assign host.clr_cmd_rdy = clr_q;
  assign raddr            = raddr_q;

endmodule

// File: tb/tb_cmd_cfg_gen.sv
// Scoreboard bench for cmd_cfg_gen against an array-based register and RAM model.
module tb_cmd_cfg_gen;
  localparam int NUM_CH  = 5;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic clk = 1'b0;
  logic rst;
  logic set_capture_done;
  logic [LOG2-1:0] start_addr, raddr, trig_pos;
  logic [NUM_CH*8-1:0] rdata;
  logic [3:0] decimator;
  logic [7:0] maskL, maskH, matchL, matchH, baud_cntL, baud_cntH;
  logic [5:0] TrigCfg;
  logic [NUM_CH*5-1:0] ChTrigCfg;

  cmd_cfg_gen_if host_if ();

  cmd_cfg_gen #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .host(host_if), .set_capture_done(set_capture_done),
    .start_addr(start_addr), .rdata(rdata), .raddr(raddr), .trig_pos(trig_pos),
    .decimator(decimator), .maskL(maskL), .maskH(maskH), .matchL(matchL), .matchH(matchH),
    .baud_cntL(baud_cntL), .baud_cntH(baud_cntH), .TrigCfg(TrigCfg), .ChTrigCfg(ChTrigCfg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_sent = 0;
  int n_clr  = 0;
  bit dump_active = 1'b0;
  bit dump_bit4 = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] mreg [32];
  logic [7:0] mem [NUM_CH][ENTRIES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Channel RAM with one cycle of read latency.
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) rdata[c*8 +: 8] <= mem[c][raddr];
  end

  always @(negedge clk) if (host_if.clr_cmd_rdy === 1'b1) n_clr++;

  // UART side: score every byte presented, then acknowledge after a random delay.
  initial begin
    logic [7:0] e;
    host_if.resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (host_if.send_resp === 1'b1) begin
        n_sent++;
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(host_if.resp), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("resp", 32'(host_if.resp), 32'(e));
        end
        if (dump_active) chk("trigcfg_bit4_during_dump", 32'(TrigCfg[4]), 32'(dump_bit4));
        @(negedge clk);
        chk("send_resp_one_cycle", 32'(host_if.send_resp), 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        host_if.resp_sent = 1'b1;
        @(negedge clk);
        host_if.resp_sent = 1'b0;
      end
    end
  end

  function automatic bit m_mapped(input int a);
    return (a <= 11) || (a >= 16 && a < 16 + NUM_CH);
  endfunction

  function automatic logic [7:0] m_mask(input int a);
    if (a == 0) return 8'h3F;
    if (a == 1) return 8'h0F;
    if (a == 10) return 8'((1 << (LOG2 - 8)) - 1);
    if (a >= 16) return 8'h1F;
    return 8'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 8'h00;
    mreg[0] = 8'h03; mreg[2] = 8'hAA; mreg[3] = 8'h55;
    mreg[8] = 8'h06; mreg[9] = 8'hC8; mreg[11] = 8'h01;
    for (int n = 0; n < NUM_CH; n++) mreg[16 + n] = 8'h01;
  endtask

  task automatic check_outputs();
    chk("TrigCfg", 32'(TrigCfg), 32'(mreg[0]));
    chk("decimator", 32'(decimator), 32'(mreg[1]));
    chk("matchH", 32'(matchH), 32'(mreg[4]));
    chk("matchL", 32'(matchL), 32'(mreg[5]));
    chk("maskH", 32'(maskH), 32'(mreg[6]));
    chk("maskL", 32'(maskL), 32'(mreg[7]));
    chk("baud_cnt", {16'h0, baud_cntH, baud_cntL}, {16'h0, mreg[8], mreg[9]});
    chk("trig_pos", 32'(trig_pos), (32'(mreg[10]) << 8) | 32'(mreg[11]));
    for (int n = 0; n < NUM_CH; n++) chk("ChTrigCfg", 32'(ChTrigCfg[n*5 +: 5]), 32'(mreg[16 + n]));
  endtask

  task automatic do_cmd(input logic [15:0] c, input bit scd, input int budget, input bit short_cmd);
    int cyc;
    bit seen;
    @(negedge clk);
    host_if.cmd = c;
    host_if.cmd_rdy = 1'b1;
    set_capture_done = scd;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      set_capture_done = 1'b0;
      cyc++;
      if (host_if.clr_cmd_rdy === 1'b1) seen = 1'b1;
    end
    host_if.cmd_rdy = 1'b0;
    chk("clr_cmd_rdy_seen", 32'(seen), 1);
    if (seen && short_cmd) chk("resp_latency", cyc, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic rd(input int a);
    exp_q.push_back(m_mapped(a) ? mreg[a] : 8'hEE);
    do_cmd({3'b000, 5'(a), 8'h00}, 1'b0, 20, 1'b1);
  endtask

  task automatic wr(input int a, input logic [7:0] d, input bit scd);
    if (m_mapped(a)) begin
      exp_q.push_back(8'hA5);
      mreg[a] = d & m_mask(a);
    end else begin
      exp_q.push_back(8'hEE);
    end
    if (scd) mreg[0][4] = 1'b1;
    do_cmd({3'b010, 5'(a), d}, scd, 20, 1'b1);
  endtask

  task automatic dump(input int ch, input int start);
    int s0, c0;
    start_addr = LOG2'(start);
    if (ch < 1 || ch > NUM_CH) begin
      exp_q.push_back(8'hEE);
      do_cmd({3'b100, 5'(ch), 8'h00}, 1'b0, 20, 1'b1);
    end else begin
      for (int i = 0; i < ENTRIES; i++) exp_q.push_back(mem[ch-1][(start + i) % ENTRIES]);
      s0 = n_sent;
      c0 = n_clr;
      dump_bit4 = mreg[0][4];
      dump_active = 1'b1;
      do_cmd({3'b100, 5'(ch), 8'h00}, 1'b0, ENTRIES * 16, 1'b0);
      dump_active = 1'b0;
      mreg[0][4] = 1'b0;
      chk("dump_byte_count", n_sent - s0, ENTRIES);
      chk("dump_clr_pulses", n_clr - c0, 1);
    end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LOG2-1:0] ra;
    int s0, c0, k;
    rst = 1'b1;
    set_capture_done = 1'b0;
    start_addr = '0;
    host_if.cmd = '0;
    host_if.cmd_rdy = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < ENTRIES; a++) mem[c][a] = 8'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_outputs();
    chk("reset_resp", 32'(host_if.resp), 0);
    chk("reset_send_resp", 32'(host_if.send_resp), 0);
    chk("reset_clr_cmd_rdy", 32'(host_if.clr_cmd_rdy), 0);
    chk("reset_raddr", 32'(raddr), 0);

    for (int a = 0; a <= 11; a++) rd(a);
    for (int n = 0; n < NUM_CH; n++) rd(16 + n);

    wr(8'h0A, 8'h01, 1'b0);
    wr(8'h0B, 8'hFF, 1'b0);
    check_outputs();
    chk("trig_pos_1ff", 32'(trig_pos), 32'h1FF);
    rd(8'h0A);

    wr(8'h13, 8'h05, 1'b0);
    check_outputs();
    rd(8'h1F);
    wr(8'h0C, 8'h12, 1'b0);
    exp_q.push_back(8'hEE);
    do_cmd(16'hC000, 1'b0, 20, 1'b1);
    check_outputs();

    @(negedge clk);
    set_capture_done = 1'b1;
    @(negedge clk);
    set_capture_done = 1'b0;
    mreg[0][4] = 1'b1;
    check_outputs();
    dump(2, 380);
    check_outputs();

    ra = raddr;
    dump(0, 5);
    dump(6, 7);
    chk("nak_dump_raddr_still", 32'(raddr), 32'(ra));
    chk("nak_dump_raddr_value", 32'(raddr), 379);

    wr(8'h00, 8'h00, 1'b1);
    check_outputs();
    chk("trigcfg_write_vs_capture_done", 32'(TrigCfg), 32'h10);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      if (k == 0) rd($urandom_range(0, 31));
      else if (k == 1) wr($urandom_range(0, 31), 8'($urandom), ($urandom_range(0, 7) == 0));
      else check_outputs();
    end
    dump($urandom_range(1, NUM_CH), $urandom_range(0, ENTRIES - 1));
    check_outputs();

    // Reset partway through a dump.
    start_addr = LOG2'($urandom_range(0, ENTRIES - 1));
    for (int i = 0; i < ENTRIES; i++) exp_q.push_back(mem[2][(int'(start_addr) + i) % ENTRIES]);
    s0 = n_sent;
    c0 = n_clr;
    @(negedge clk);
    host_if.cmd = 16'h8300;
    host_if.cmd_rdy = 1'b1;
    k = 0;
    while ((n_sent - s0) < 100 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("reached_byte_100", 32'((n_sent - s0) >= 100), 1);
    rst = 1'b1;
    host_if.cmd_rdy = 1'b0;
    @(negedge clk);
    exp_q.delete();
    model_reset();
    s0 = n_sent;
    chk("midreset_raddr", 32'(raddr), 0);
    chk("midreset_send_resp", 32'(host_if.send_resp), 0);
    chk("midreset_clr", 32'(host_if.clr_cmd_rdy), 0);
    chk("midreset_resp", 32'(host_if.resp), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midreset_no_sends", n_sent - s0, 0);
    chk("midreset_no_clr", n_clr - c0, 0);
    chk("midreset_raddr_idle", 32'(raddr), 0);
    check_outputs();
    rd(8'h00);
    rd(8'h13);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
